// File: rtl/classifier_batch_driver_pkg.sv
// Shared types and sample-word layout for the classifier batch driver.
// Sample word layout, MSB to LSB: {label, f4, f3, f2, f1, f0}.
package classifier_batch_driver_pkg;

  localparam int FEAT_W_DEF  = 32;
  localparam int CLASS_W_DEF = 3;
  localparam int NUM_FEAT    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Bit offset of feature i inside a packed sample word.
  function automatic int feat_lsb(input int i, input int feat_w);
    return i * feat_w;
  endfunction

  // Bit offset of the label, which sits above the five features.
  function automatic int label_lsb(input int feat_w);
    return NUM_FEAT * feat_w;
  endfunction

endpackage

// File: rtl/classifier_batch_driver.sv
// Streams a stored batch of samples through decision_tree and tallies
// correct, wrong and timed-out classifications.
module classifier_batch_driver
  import classifier_batch_driver_pkg::*;
#(
  parameter int NUM_SAMPLES = 665,
  parameter int FEAT_W      = FEAT_W_DEF,
  parameter int CLASS_W     = CLASS_W_DEF,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              run,
  output logic                              mem_rd_en,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic [NUM_FEAT*FEAT_W+CLASS_W-1:0] mem_rdata,
  output logic                              start,
  output logic [FEAT_W-1:0]                 feature0,
  output logic [FEAT_W-1:0]                 feature1,
  output logic [FEAT_W-1:0]                 feature2,
  output logic [FEAT_W-1:0]                 feature3,
  output logic [FEAT_W-1:0]                 feature4,
  input  logic [CLASS_W-1:0]                dt_class,
  input  logic                              dt_valid,
  output logic                              active,
  output logic                              done,
  output logic [ADDR_W:0]                   correct_cnt,
  output logic [ADDR_W:0]                   error_cnt,
  output logic [ADDR_W:0]                   timeout_cnt
);

  localparam int CNT_W     = ADDR_W + 1;
  localparam int WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LABEL_LSB = label_lsb(FEAT_W);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_SAMPLES - 1);
  // The timeout fires on the TIMEOUT-th WAIT cycle; the counter starts at 0.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e              state;
  logic [ADDR_W-1:0]   idx;
  logic [CLASS_W-1:0]  label;
  logic [WAIT_W-1:0]   wait_cnt;

  assign mem_addr = idx;

  // NOTE: every register here is state, so all assignments are non-blocking;
  // a blocking write would make later reads in this block see the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      label       <= '0;
      wait_cnt    <= '0;
      mem_rd_en   <= 1'b0;
      start       <= 1'b0;
      active      <= 1'b0;
      done        <= 1'b0;
      feature0    <= '0;
      feature1    <= '0;
      feature2    <= '0;
      feature3    <= '0;
      feature4    <= '0;
      correct_cnt <= '0;
      error_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state       <= ST_FETCH;
            active      <= 1'b1;
            mem_rd_en   <= 1'b1;
            idx         <= '0;
            correct_cnt <= '0;
            error_cnt   <= '0;
            timeout_cnt <= '0;
          end
        end

        ST_FETCH: begin
          mem_rd_en <= 1'b0;
          state     <= ST_LOAD;
        end

        ST_LOAD: begin
          feature0 <= mem_rdata[feat_lsb(0, FEAT_W) +: FEAT_W];
          feature1 <= mem_rdata[feat_lsb(1, FEAT_W) +: FEAT_W];
          feature2 <= mem_rdata[feat_lsb(2, FEAT_W) +: FEAT_W];
          feature3 <= mem_rdata[feat_lsb(3, FEAT_W) +: FEAT_W];
          feature4 <= mem_rdata[feat_lsb(4, FEAT_W) +: FEAT_W];
          label    <= mem_rdata[LABEL_LSB +: CLASS_W];
          start    <= 1'b1;
          state    <= ST_ISSUE;
        end

        ST_ISSUE: begin
          start    <= 1'b0;
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          // A result arriving on the expiry cycle is still scored as a compare.
          if (dt_valid || (wait_cnt == WAIT_LAST)) begin
            if (!dt_valid)
              timeout_cnt <= timeout_cnt + CNT_W'(1);
            else if (dt_class == label)
              correct_cnt <= correct_cnt + CNT_W'(1);
            else
              error_cnt   <= error_cnt + CNT_W'(1);

            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx       <= idx + ADDR_W'(1);
              mem_rd_en <= 1'b1;
              state     <= ST_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_DONE: begin
          done   <= 1'b0;
          active <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_classifier_batch_driver.sv
// Directed bench: behavioural sample ROM plus a stub classifier with
// programmable latency, returned class and a per-sample silence mask.
module tb_classifier_batch_driver;
  import classifier_batch_driver_pkg::*;

  localparam int NS = 4;
  localparam int FW = 32;
  localparam int CW = 3;
  localparam int AW = 10;
  localparam int TO = 8;
  localparam int WW = NUM_FEAT * FW + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_rdata = '0;
  logic          start;
  logic [FW-1:0] feature0, feature1, feature2, feature3, feature4;
  logic [CW-1:0] dt_class;
  logic          dt_valid;
  logic          active, done;
  logic [AW:0]   correct_cnt, error_cnt, timeout_cnt;

  logic [WW-1:0] rom [NS];
  int            lat         = 2;
  logic          use_label   = 1'b1;
  logic [CW-1:0] const_class = '0;
  int            skip_idx    = -1;
  logic          spurious    = 1'b0;
  int            cd          = 0;

  int checks = 0;
  int errors = 0;
  int start_wide = 0;
  int done_wide  = 0;
  logic start_q = 1'b0;
  logic done_q  = 1'b0;

  classifier_batch_driver #(
    .NUM_SAMPLES(NS), .FEAT_W(FW), .CLASS_W(CW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .start(start),
    .feature0(feature0), .feature1(feature1), .feature2(feature2),
    .feature3(feature3), .feature4(feature4),
    .dt_class(dt_class), .dt_valid(dt_valid),
    .active(active), .done(done),
    .correct_cnt(correct_cnt), .error_cnt(error_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  // Sample memory: one-cycle registered read.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= rom[mem_addr[1:0]];

  // Stub classifier: valid pulses lat cycles after the start edge.
  always @(posedge clk) begin
    if (start) cd <= lat;
    else if (cd != 0) cd <= cd - 1;
  end
  assign dt_valid = ((cd == 1) && (int'(mem_addr) != skip_idx)) || spurious;
  assign dt_class = use_label ? rom[mem_addr[1:0]][WW-1 -: CW] : const_class;

  // Pulse-width monitors for start and done.
  always @(negedge clk) begin
    if (start && start_q) start_wide++;
    if (done && done_q) done_wide++;
    start_q = start;
    done_q  = done;
  end

  function automatic logic [FW-1:0] feat(input int s, input int i);
    return FW'(32'hA500_0000 + s * 16 + i);
  endfunction

  task automatic load_rom(input logic [CW-1:0] l0, l1, l2, l3);
    logic [CW-1:0] lab [NS];
    lab = '{l0, l1, l2, l3};
    for (int s = 0; s < NS; s++)
      rom[s] = {lab[s], feat(s, 4), feat(s, 3), feat(s, 2), feat(s, 1), feat(s, 0)};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick;
      n++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic check_counts(input string tag, input int cc, input int ec, input int tc);
    check({tag, "_correct"}, 64'(correct_cnt), 64'(cc));
    check({tag, "_error"}, 64'(error_cnt), 64'(ec));
    check({tag, "_timeout"}, 64'(timeout_cnt), 64'(tc));
    check({tag, "_sum"}, 64'(correct_cnt + error_cnt + timeout_cnt), 64'(NS));
  endtask

  task automatic run_batch(input string tag, input int exp_n,
                           input int cc, input int ec, input int tc);
    int n;
    run = 1'b1;
    tick;
    run = 1'b0;
    check({tag, "_active"}, 64'(active), 64'd1);
    check({tag, "_fetch0"}, 64'({mem_rd_en, mem_addr}), 64'({1'b1, AW'(0)}));
    wait_done(tag, 200, n);
    check({tag, "_cycles"}, 64'(n), 64'(exp_n));
    check({tag, "_active_at_done"}, 64'(active), 64'd1);
    check_counts(tag, cc, ec, tc);
    tick;
    check({tag, "_idle_after"}, 64'({active, done}), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctrl"}, 64'({active, done, start, mem_rd_en}), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_feat"}, 64'(feature0 | feature1 | feature2 | feature3 | feature4), 64'd0);
    check({tag, "_cnts"}, 64'({correct_cnt, error_cnt, timeout_cnt}), 64'd0);
  endtask

  initial begin
    int n;
    load_rom(3'd3, 3'd1, 3'd0, 3'd2);
    repeat (3) tick;
    rst = 1'b0;
    check_reset("reset");

    // Matching classifier, latency 2: 5 cycles per sample.
    run_batch("match", 20, 4, 0, 0);
    check("feat_last0", 64'(feature0), 64'(feat(3, 0)));
    check("feat_last4", 64'(feature4), 64'(feat(3, 4)));

    // Constant class 1 against labels 0..3.
    load_rom(3'd0, 3'd1, 3'd2, 3'd3);
    use_label = 1'b0;
    const_class = 3'd1;
    run_batch("const1", 20, 1, 3, 0);

    // Spurious valid while idle leaves the held counters alone.
    spurious = 1'b1;
    repeat (3) tick;
    spurious = 1'b0;
    check("idle_spurious_active", 64'(active), 64'd0);
    check_counts("idle_spurious", 1, 3, 0);

    // Sample 2 never answers: 3*5 + (3+8) cycles.
    use_label = 1'b1;
    skip_idx = 2;
    run_batch("skip2", 26, 3, 0, 1);
    skip_idx = -1;

    // Valid on the exact expiry cycle counts as a compare.
    use_label = 1'b0;
    const_class = 3'd0;
    lat = TO;
    run_batch("edge_valid", 44, 1, 3, 0);

    // One cycle later is a timeout for every sample.
    lat = TO + 1;
    run_batch("late_valid", 44, 0, 0, 4);

    // Spurious valid through FETCH and a second run mid-batch.
    lat = 2;
    use_label = 1'b1;
    load_rom(3'd3, 3'd1, 3'd0, 3'd2);
    spurious = 1'b1;
    run = 1'b1;
    tick;
    run = 1'b0;
    check("fetch_spurious_cnts", 64'({correct_cnt, error_cnt, timeout_cnt}), 64'd0);
    tick;
    spurious = 1'b0;
    run = 1'b1;
    tick;
    run = 1'b0;
    check("rerun_issue_start", 64'(start), 64'd1);
    wait_done("rerun", 200, n);
    check("rerun_cycles", 64'(n), 64'd18);
    check_counts("rerun", 4, 0, 0);
    tick;

    // Reset while sample 1 is in WAIT, then restart from index 0.
    run = 1'b1;
    tick;
    run = 1'b0;
    repeat (8) tick;
    check("midwait_state", 64'({active, start, mem_addr}), 64'({1'b1, 1'b0, AW'(1)}));
    check("midwait_correct", 64'(correct_cnt), 64'd1);
    rst = 1'b1;
    tick;
    check_reset("midreset");
    rst = 1'b0;
    tick;
    check("midreset_no_done", 64'({active, done}), 64'd0);
    run_batch("restart", 20, 4, 0, 0);

    check("start_width", 64'(start_wide), 64'd0);
    check("done_width", 64'(done_wide), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
